radio_capture: RTL

RADIO_CAPTURE -- requirements
Module: radio_capture

---
 rtl/radio_pkg.sv | 21 ++
 rtl/radio_capture_if.sv | 63 ++++++
 rtl/radio_sat_round.sv | 32 +++
 rtl/radio_capture.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// Shared definitions for the radio capture block.
//   NUM_LANES      : number of parallel ADC lanes (each carries one I and one Q sample)
//   captureState_e : capture FSM state encoding
//   laneSample_t   : one FIFO entry, with the requantized I and Q byte of every lane
//                    plus the end-of-packet tag
package radio_pkg;

  localparam int NUM_LANES = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } captureState_e;

  typedef struct packed {
    logic                      last;
    logic [NUM_LANES-1:0][7:0] q;
    logic [NUM_LANES-1:0][7:0] i;
  } laneSample_t;

endpackage

// File: rtl/radio_capture_if.sv
// Bundle of control, ADC input and per-lane output stream signals for radio_capture.
//   control : start, abort, cont_mode, pkt_len
//   ADC in  : s_axis_adc_tvalid, s_axis_adcI_tdata[], s_axis_adcQ_tdata[]
//   out     : m_axis_output{I,Q}_{tvalid,tready,tdata,tlast}[]
//   status  : busy, overflow, fifo_level, dbgState (current FSM state)
// Modport slave is the capture block; modport master is whoever drives it.
//
// Handshake: an output beat transfers on a cycle where its tvalid and tready are
// both high. Once tvalid is high it stays high with tdata/tlast unchanged until
// the beat transfers. All lanes share one FIFO head, so a beat transfers on every
// lane together, only when all I and Q tready inputs are high. The ADC side has
// no ready: every cycle with s_axis_adc_tvalid high carries a sample.
interface radio_capture_if #(
  parameter int FIFO_DEPTH = 16
);
  import radio_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 start;
  logic                 abort;
  logic                 cont_mode;
  logic [15:0]          pkt_len;

  logic                 s_axis_adc_tvalid;
  logic [15:0]          s_axis_adcI_tdata [NUM_LANES];
  logic [15:0]          s_axis_adcQ_tdata [NUM_LANES];

  logic                 m_axis_outputI_tvalid [NUM_LANES];
  logic                 m_axis_outputQ_tvalid [NUM_LANES];
  logic                 m_axis_outputI_tready [NUM_LANES];
  logic                 m_axis_outputQ_tready [NUM_LANES];
  logic [7:0]           m_axis_outputI_tdata  [NUM_LANES];
  logic [7:0]           m_axis_outputQ_tdata  [NUM_LANES];
  logic                 m_axis_outputI_tlast  [NUM_LANES];
  logic                 m_axis_outputQ_tlast  [NUM_LANES];

  logic                 busy;
  logic                 overflow;
  logic [LEVEL_W-1:0]   fifo_level;
  captureState_e        dbgState;

  modport master (
    output start, abort, cont_mode, pkt_len,
    output s_axis_adc_tvalid, s_axis_adcI_tdata, s_axis_adcQ_tdata,
    output m_axis_outputI_tready, m_axis_outputQ_tready,
    input  m_axis_outputI_tvalid, m_axis_outputQ_tvalid,
    input  m_axis_outputI_tdata, m_axis_outputQ_tdata,
    input  m_axis_outputI_tlast, m_axis_outputQ_tlast,
    input  busy, overflow, fifo_level, dbgState
  );

  modport slave (
    input  start, abort, cont_mode, pkt_len,
    input  s_axis_adc_tvalid, s_axis_adcI_tdata, s_axis_adcQ_tdata,
    input  m_axis_outputI_tready, m_axis_outputQ_tready,
    output m_axis_outputI_tvalid, m_axis_outputQ_tvalid,
    output m_axis_outputI_tdata, m_axis_outputQ_tdata,
    output m_axis_outputI_tlast, m_axis_outputQ_tlast,
    output busy, overflow, fifo_level, dbgState
  );

endinterface

// File: rtl/radio_sat_round.sv
// Requantizes one signed 16-bit sample to signed 8 bits.
//   x : signed 16-bit input sample
//   q : round-half-up of x / 2^SHIFT, saturated to [-128, 127]
// Purely combinational; the caller registers the result.
module radio_sat_round #(
  parameter int SHIFT = 8
) (
  input  logic [15:0] x,
  output logic [7:0]  q
);

  // 17 bits so that adding the rounding constant to 0x7FFF cannot wrap.
  localparam logic signed [16:0] HALF  = 17'sd1 <<< (SHIFT - 1);
  localparam logic signed [16:0] MAX_Q = 17'sd127;
  localparam logic signed [16:0] MIN_Q = -17'sd128;

  logic signed [16:0] sum;
  logic signed [16:0] shifted;

  always_comb begin
    sum     = $signed({x[15], x}) + HALF;
    shifted = sum >>> SHIFT;
    if (shifted > MAX_Q) begin
      q = 8'h7F;
    end else if (shifted < MIN_Q) begin
      q = 8'h80;
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/radio_capture.sv
// Multi-lane ADC packet capture: requantizes 8 lanes of I/Q to 8 bits, tags
// packet boundaries and buffers the result in a shared first-word-fall-through
// FIFO drained in lock-step by all 16 output streams.
//   clk_250m : sole clock, rising edge
//   reset    : synchronous, active-high
//   bus      : radio_capture_if slave (control, ADC input, output streams, status)
module radio_capture
  import radio_pkg::*;
#(
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic             clk_250m,
  input logic             reset,
  radio_capture_if.slave  bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  captureState_e     state;
  captureState_e     stateNext;
  logic [15:0]       pktLenReg;
  logic [15:0]       sampleCnt;
  logic              startOk;
  logic              takeSample;
  logic              isLast;
  logic              overflowReg;

  logic [7:0]        qI [NUM_LANES];
  logic [7:0]        qQ [NUM_LANES];
  laneSample_t       quant;
  laneSample_t       stage;
  logic              stageValid;

  laneSample_t       mem [FIFO_DEPTH];
  laneSample_t       head;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [LEVEL_W-1:0] count;
  logic              full;
  logic              empty;
  logic              allReady;
  logic              pop;
  logic              write;
  logic              drop;

  assign startOk    = (state == IDLE) && bus.start && (bus.pkt_len != 16'd0);
  // A sample arriving together with abort is discarded, including a last sample.
  assign takeSample = (state == CAPTURE) && bus.s_axis_adc_tvalid && !bus.abort;
  assign isLast     = (sampleCnt == (pktLenReg - 16'd1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk_250m) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    bus.busy     = 1'b0;
    bus.dbgState = state;
    case (state)
      IDLE: begin
        if (startOk) stateNext = CAPTURE;
      end
      CAPTURE: begin
        bus.busy = 1'b1;
        if (bus.abort) begin
          stateNext = IDLE;
        end else if (takeSample && isLast && !bus.cont_mode) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sample counter and sticky overflow. A drop in the same cycle as an accepted
  // start still leaves overflow set, so no dropped sample ever goes unreported.
  always_ff @(posedge clk_250m) begin
    if (reset) begin
      pktLenReg   <= 16'd0;
      sampleCnt   <= 16'd0;
      overflowReg <= 1'b0;
    end else begin
      if (startOk) begin
        pktLenReg <= bus.pkt_len;
        sampleCnt <= 16'd0;
      end else if (takeSample) begin
        sampleCnt <= isLast ? 16'd0 : sampleCnt + 16'd1;
      end
      if (drop) begin
        overflowReg <= 1'b1;
      end else if (startOk) begin
        overflowReg <= 1'b0;
      end
    end
  end

  assign bus.overflow = overflowReg;

  // ---------------- requantization stage ----------------
  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    radio_sat_round #(.SHIFT(SHIFT)) uRoundI (.x(bus.s_axis_adcI_tdata[g]), .q(qI[g]));
    radio_sat_round #(.SHIFT(SHIFT)) uRoundQ (.x(bus.s_axis_adcQ_tdata[g]), .q(qQ[g]));
  end

  always_comb begin
    quant      = '0;
    quant.last = isLast;
    for (int l = 0; l < NUM_LANES; l++) begin
      quant.i[l] = qI[l];
      quant.q[l] = qQ[l];
    end
  end

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      stageValid <= 1'b0;
      stage      <= '0;
    end else begin
      stageValid <= takeSample;
      if (takeSample) stage <= quant;
    end
  end

  // ---------------- shared FWFT FIFO ----------------
  assign full  = (count == LEVEL_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && allReady;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign write = stageValid && (!full || pop);
  assign drop  = stageValid && full && !pop;
  assign head  = mem[rdPtr];

  always_ff @(posedge clk_250m) begin
    if (write) mem[wrPtr] <= stage;
  end

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (write) wrPtr <= wrPtr + 1'b1;
      if (pop)   rdPtr <= rdPtr + 1'b1;
      count <= count + LEVEL_W'(write) - LEVEL_W'(pop);
    end
  end

  assign bus.fifo_level = count;

  // Outputs are forced to zero while empty so stale memory never shows after reset.
  always_comb begin
    allReady = 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      allReady = allReady & bus.m_axis_outputI_tready[l] & bus.m_axis_outputQ_tready[l];
      bus.m_axis_outputI_tvalid[l] = !empty;
      bus.m_axis_outputQ_tvalid[l] = !empty;
      bus.m_axis_outputI_tdata[l]  = empty ? 8'h00 : head.i[l];
      bus.m_axis_outputQ_tdata[l]  = empty ? 8'h00 : head.q[l];
      bus.m_axis_outputI_tlast[l]  = !empty && head.last;
      bus.m_axis_outputQ_tlast[l]  = !empty && head.last;
    end
  end

endmodule
